// File: rtl/sc_transeq_pkg.sv
// Shared codes, state encoding and frame-pattern decode for the transition sequencer.
package sc_transeq_pkg;

  localparam logic [2:0] TRANS_NONE = 3'b000;
  localparam logic [2:0] TRANS_WIN  = 3'b001;
  localparam logic [2:0] TRANS_LOSE = 3'b010;

  localparam logic [7:0] LOSE_EVEN = 8'hAA;
  localparam logic [7:0] LOSE_ODD  = 8'h55;

  localparam int unsigned NUM_FRAMES = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } transeq_state_e;

  // Win frame k lights the lower k+1 bits; lose alternates AA/55.
  function automatic logic [7:0] frame_pattern(input logic lose, input logic [2:0] frame);
    logic [7:0] pat;
    if (lose) begin
      pat = frame[0] ? LOSE_ODD : LOSE_EVEN;
    end else begin
      pat = 8'hFF >> (3'd7 - frame);
    end
    return pat;
  endfunction

endpackage

// File: rtl/sc_transition_sequencer_sc_tick_prescaler.sv
// Modulo-FRAME_TICKS counter with enable and clear; tc_o pulses on the enabled terminal count.
module sc_tick_prescaler #(
  parameter int unsigned FRAME_TICKS    = 25000000,
  parameter int unsigned TICK_CNT_WIDTH = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  logic [TICK_CNT_WIDTH-1:0] tick_q;
  logic [TICK_CNT_WIDTH-1:0] tick_d;
  logic                      at_max;

  assign at_max = (tick_q == TICK_CNT_WIDTH'(FRAME_TICKS - 1));
  assign tc_o   = en_i && !clr_i && at_max;

  always_comb begin
    tick_d = tick_q;
    if (clr_i) begin
      tick_d = '0;
    end else if (en_i) begin
      tick_d = at_max ? '0 : tick_q + TICK_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/sc_transition_sequencer.sv
// Plays the 8-frame win/lose animation that feeds the background-row transition inputs.
module sc_transition_sequencer
  import sc_transeq_pkg::*;
#(
  parameter int unsigned TRANSEQ_DATAWIDTH = 8,
  parameter int unsigned FRAME_TICKS       = 25000000,
  parameter int unsigned TICK_CNT_WIDTH    = 25
) (
  input  logic                         SC_TransSEQ_CLOCK_50,
  input  logic                         SC_TransSEQ_RESET_InHigh,
  input  logic                         SC_TransSEQ_startWIN_InLow,
  input  logic                         SC_TransSEQ_startLOSE_InLow,
  input  logic                         SC_TransSEQ_abort_InLow,
  input  logic                         SC_TransSEQ_pause_InLow,
  output logic [2:0]                   SC_TransSEQ_transition_OutBUS,
  output logic [TRANSEQ_DATAWIDTH-1:0] SC_TransSEQ_transitionDATA_OutBUS,
  output logic                         SC_TransSEQ_busy_Out,
  output logic                         SC_TransSEQ_done_Out
);

  transeq_state_e state_q;
  logic [2:0]     frame_q;
  logic [2:0]     frame_d;
  logic           lose_q;
  logic [2:0]     trans_q;
  logic [7:0]     data_q;
  logic           busy_q;
  logic           done_q;

  logic abort;
  logic start_any;
  logic tick_en;
  logic tick_clr;
  logic frame_tc;

  assign abort     = !SC_TransSEQ_abort_InLow;
  assign start_any = !SC_TransSEQ_startWIN_InLow || !SC_TransSEQ_startLOSE_InLow;
  assign frame_d   = frame_q + 3'd1;

  // Counter is held at zero outside RUN so every run starts on a fresh frame.
  assign tick_en  = (state_q == ST_RUN) && SC_TransSEQ_pause_InLow;
  assign tick_clr = (state_q == ST_IDLE) || abort;

  sc_tick_prescaler #(
    .FRAME_TICKS    (FRAME_TICKS),
    .TICK_CNT_WIDTH (TICK_CNT_WIDTH)
  ) u_prescaler (
    .clk_i (SC_TransSEQ_CLOCK_50),
    .rst_i (SC_TransSEQ_RESET_InHigh),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .tc_o  (frame_tc)
  );

  always_ff @(posedge SC_TransSEQ_CLOCK_50) begin
    if (SC_TransSEQ_RESET_InHigh) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      lose_q  <= 1'b0;
      trans_q <= TRANS_NONE;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!abort && start_any) begin
            state_q <= ST_RUN;
            frame_q <= '0;
            lose_q  <= SC_TransSEQ_startWIN_InLow;
            trans_q <= SC_TransSEQ_startWIN_InLow ? TRANS_LOSE : TRANS_WIN;
            data_q  <= frame_pattern(SC_TransSEQ_startWIN_InLow, 3'd0);
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            trans_q <= TRANS_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
          end else if (frame_tc) begin
            if (frame_q == 3'(NUM_FRAMES - 1)) begin
              state_q <= ST_IDLE;
              frame_q <= '0;
              trans_q <= TRANS_NONE;
              data_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              frame_q <= frame_d;
              data_q  <= frame_pattern(lose_q, frame_d);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign SC_TransSEQ_transition_OutBUS     = trans_q;
  assign SC_TransSEQ_transitionDATA_OutBUS = data_q;
  assign SC_TransSEQ_busy_Out              = busy_q;
  assign SC_TransSEQ_done_Out              = done_q;

endmodule

// File: tb/tb_sc_transition_sequencer.sv
// Self-checking bench: elapsed-time behavioural model plus directed and random stimulus.
module tb_sc_transition_sequencer;

  localparam int FT = 4;

  logic       clk;
  logic       rst;
  logic       win_n;
  logic       lose_n;
  logic       abort_n;
  logic       pause_n;
  logic [2:0] code;
  logic [7:0] data;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  // Model: whether an animation is playing, which one, and how many unpaused cycles it has consumed.
  bit m_active;
  bit m_lose;
  int m_el;
  bit m_done;

  sc_transition_sequencer #(
    .TRANSEQ_DATAWIDTH (8),
    .FRAME_TICKS       (FT),
    .TICK_CNT_WIDTH    (3)
  ) dut (
    .SC_TransSEQ_CLOCK_50              (clk),
    .SC_TransSEQ_RESET_InHigh          (rst),
    .SC_TransSEQ_startWIN_InLow        (win_n),
    .SC_TransSEQ_startLOSE_InLow       (lose_n),
    .SC_TransSEQ_abort_InLow           (abort_n),
    .SC_TransSEQ_pause_InLow           (pause_n),
    .SC_TransSEQ_transition_OutBUS     (code),
    .SC_TransSEQ_transitionDATA_OutBUS (data),
    .SC_TransSEQ_busy_Out              (busy),
    .SC_TransSEQ_done_Out              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic int exp_pattern(input bit lose, input int frame);
    if (lose) return (frame % 2 == 1) ? 8'h55 : 8'hAA;
    return (1 << (frame + 1)) - 1;
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_el     = 0;
    end else if (m_active) begin
      if (!abort_n) begin
        m_active = 1'b0;
      end else if (pause_n) begin
        m_el++;
        if (m_el == 8 * FT) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (abort_n && (!win_n || !lose_n)) begin
      m_active = 1'b1;
      m_lose   = win_n;
      m_el     = 0;
    end
  endtask

  // One clock: model sees the inputs sampled at the edge, then all outputs are compared.
  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    chk("code", int'(code), m_active ? (m_lose ? 2 : 1) : 0);
    chk("data", int'(data), m_active ? exp_pattern(m_lose, m_el / FT) : 0);
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0;
    m_active = 0; m_lose = 0; m_el = 0; m_done = 0;
    rst = 1'b1; win_n = 1'b1; lose_n = 1'b1; abort_n = 1'b1; pause_n = 1'b1;
    go(2);
    rst = 1'b0;
    chk("rst_code", int'(code), 0);
    chk("rst_busy", int'(busy), 0);
    go(2);

    // Win run, literal frame boundaries
    win_n = 1'b0; go(1); win_n = 1'b1;
    chk("win_c1_code", int'(code), 1);
    chk("win_c1_data", int'(data), 8'h01);
    go(3);  chk("win_c4_data", int'(data), 8'h01);
    go(1);  chk("win_c5_data", int'(data), 8'h03);
    go(27); chk("win_c32_data", int'(data), 8'hFF);
    chk("win_c32_busy", int'(busy), 1);
    go(1);  chk("win_c33_done", int'(done), 1);
    chk("win_c33_code", int'(code), 0);
    chk("win_c33_data", int'(data), 0);
    go(1);  chk("win_c34_done", int'(done), 0);
    go(2);

    // Lose run
    lose_n = 1'b0; go(1); lose_n = 1'b1;
    chk("lose_c1_code", int'(code), 2);
    chk("lose_c1_data", int'(data), 8'hAA);
    go(4);  chk("lose_c5_data", int'(data), 8'h55);
    go(27); chk("lose_c32_data", int'(data), 8'h55);
    go(1);  chk("lose_c33_done", int'(done), 1);
    go(2);

    // Simultaneous start favours win; start during RUN ignored
    win_n = 1'b0; lose_n = 1'b0; go(1); win_n = 1'b1; lose_n = 1'b1;
    chk("both_code", int'(code), 1);
    go(8);  chk("both_c9_data", int'(data), 8'h07);
    go(1);  lose_n = 1'b0; go(1); lose_n = 1'b1;
    go(1);  chk("retrig_c12_data", int'(data), 8'h07);
    chk("retrig_c12_code", int'(code), 1);
    go(21); chk("both_c33_done", int'(done), 1);
    go(2);

    // Abort mid-run, then restart
    win_n = 1'b0; go(1); win_n = 1'b1;
    go(5); abort_n = 1'b0; go(1); abort_n = 1'b1;
    chk("abort_c7_code", int'(code), 0);
    chk("abort_c7_busy", int'(busy), 0);
    chk("abort_c7_done", int'(done), 0);
    go(2); win_n = 1'b0; go(1); win_n = 1'b1;
    chk("restart_code", int'(code), 1);
    chk("restart_data", int'(data), 8'h01);
    go(32); chk("restart_done", int'(done), 1);
    go(1);
    abort_n = 1'b0; win_n = 1'b0; go(1); abort_n = 1'b1; win_n = 1'b1;
    chk("abort_idle_busy", int'(busy), 0);
    go(2);

    // Pause cycles 3-12 of a win run
    win_n = 1'b0; go(1); win_n = 1'b1;
    go(2); pause_n = 1'b0; go(9);
    chk("pause_c12_data", int'(data), 8'h01);
    go(1); pause_n = 1'b1;
    chk("pause_c13_data", int'(data), 8'h01);
    go(20); chk("pause_c33_done", int'(done), 0);
    chk("pause_c33_busy", int'(busy), 1);
    go(10); chk("pause_c43_done", int'(done), 1);
    go(2);

    // Reset during a lose run
    lose_n = 1'b0; go(1); lose_n = 1'b1;
    go(14); rst = 1'b1; go(1); rst = 1'b0;
    chk("rst_mid_code", int'(code), 0);
    chk("rst_mid_data", int'(data), 0);
    chk("rst_mid_busy", int'(busy), 0);
    go(40);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      win_n   = ($urandom_range(0, 19) != 0);
      lose_n  = ($urandom_range(0, 19) != 0);
      abort_n = ($urandom_range(0, 59) != 0);
      pause_n = ($urandom_range(0, 5) != 0);
      rst     = ($urandom_range(0, 299) == 0);
      go(1);
    end
    rst = 1'b0; win_n = 1'b1; lose_n = 1'b1; abort_n = 1'b1; pause_n = 1'b1;
    go(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
